// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// ifu_pkg : shared IFU types and constants (instruction word, ibuf pointers)
// Revision: 1.0
// ============================================================================
package ifu_pkg;

   localparam int IFU_INST_LEN   = 32;
   localparam int IFU_IBUF_AW    = 4;
   localparam int IFU_IBUF_DEPTH = 1 << IFU_IBUF_AW;

   // Extra MSB distinguishes full from empty when the index bits match.
   typedef logic [IFU_IBUF_AW:0] ptr_t;

   function automatic logic [IFU_IBUF_AW-1:0] lane_idx(input ptr_t ptr, input int unsigned i);
      ptr_t sum;
      sum = ptr + ptr_t'(i);
      return sum[IFU_IBUF_AW-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_ibuf_wdec.sv
`default_nettype none
// ============================================================================
// ifu_ibuf_wdec : per-entry write enable/data decode for a multi-lane ring
// Revision: 1.0
// ============================================================================
module ifu_ibuf_wdec
   import ifu_pkg::*;
#(
   parameter int DATA_LEN   = IFU_INST_LEN,
   parameter int ADDR_WIDTH = IFU_IBUF_AW,
   parameter int ENQ_WIDTH  = 2,
   localparam int DEPTH     = 1 << ADDR_WIDTH,
   localparam int EW        = $clog2(ENQ_WIDTH + 1)
) (
   input  logic [ADDR_WIDTH-1:0]         widx,
   input  logic [EW-1:0]                 enq_num,
   input  logic [ENQ_WIDTH*DATA_LEN-1:0] enq_data,
   output logic [DEPTH-1:0]              wr_en,
   output logic [DEPTH*DATA_LEN-1:0]     wr_data
);

   for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      logic [ADDR_WIDTH-1:0] ofs;
      logic                  en;
      logic [DATA_LEN-1:0]   d;

      // Distance from the write index tells which lane (if any) targets this entry.
      assign ofs = ADDR_WIDTH'(e) - widx;

      always_comb begin
         en = 1'b0;
         d  = '0;
         for (int l = 0; l < ENQ_WIDTH; l++) begin
            if (ofs == ADDR_WIDTH'(l)) begin
               en = (EW'(l) < enq_num);
               d  = enq_data[l*DATA_LEN +: DATA_LEN];
            end
         end
      end

      assign wr_en[e]                        = en;
      assign wr_data[e*DATA_LEN +: DATA_LEN] = d;
   end

endmodule
`default_nettype wire

// File: rtl/ifu_ibuf_mp.sv
`default_nettype none
// ============================================================================
// ifu_ibuf_mp : multi-lane fetch-to-decode instruction ring buffer with flush
// Revision: 1.0
// ============================================================================
module ifu_ibuf_mp
   import ifu_pkg::*;
#(
   parameter int DATA_LEN   = IFU_INST_LEN,
   parameter int ADDR_WIDTH = IFU_IBUF_AW,
   parameter int ENQ_WIDTH  = 2,
   parameter int DEQ_WIDTH  = 2,
   localparam int DEPTH     = 1 << ADDR_WIDTH,
   localparam int EW        = $clog2(ENQ_WIDTH + 1),
   localparam int DW        = $clog2(DEQ_WIDTH + 1),
   localparam int CW        = ADDR_WIDTH + 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic [EW-1:0]                 enq_num,
   input  logic [ENQ_WIDTH*DATA_LEN-1:0] enq_data,
   output logic                          enq_ready,
   output logic [DEQ_WIDTH-1:0]          deq_valid,
   output logic [DEQ_WIDTH*DATA_LEN-1:0] deq_data,
   input  logic [DW-1:0]                 deq_num,
   output logic [CW-1:0]                 count,
   output logic                          empty,
   output logic                          full
);

   logic [CW-1:0]             wptr;
   logic [CW-1:0]             rptr;
   logic [CW-1:0]             free;
   logic [CW-1:0]             enq_cnt;
   logic [CW-1:0]             deq_req;
   logic [CW-1:0]             deq_cnt;
   logic                      enq_fire;
   logic [EW-1:0]             wr_num;
   logic [DEPTH-1:0]          wr_en;
   logic [DEPTH*DATA_LEN-1:0] wr_data;
   logic [DATA_LEN-1:0]       mem [DEPTH];

   assign count = wptr - rptr;
   assign free  = CW'(DEPTH) - count;
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // Ready depends only on the registered pointers, never on this cycle's dequeue.
   assign enq_ready = (free >= CW'(ENQ_WIDTH));
   assign enq_fire  = enq_ready && (enq_num != '0) && !flush;
   assign wr_num    = enq_fire ? enq_num : '0;
   assign enq_cnt   = CW'(wr_num);

   assign deq_req = CW'(deq_num);
   assign deq_cnt = (deq_req > count) ? count : deq_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= rptr;
      end else begin
         wptr <= wptr + enq_cnt;
         rptr <= rptr + deq_cnt;
      end
   end

   ifu_ibuf_wdec #(
      .DATA_LEN   (DATA_LEN),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ENQ_WIDTH  (ENQ_WIDTH)
   ) u_wdec (
      .widx     (wptr[ADDR_WIDTH-1:0]),
      .enq_num  (wr_num),
      .enq_data (enq_data),
      .wr_en    (wr_en),
      .wr_data  (wr_data)
   );

   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++) begin
         if (wr_en[e]) begin
            mem[e] <= wr_data[e*DATA_LEN +: DATA_LEN];
         end
      end
   end

   for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] idx;
      assign idx                              = rptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
      assign deq_data[i*DATA_LEN +: DATA_LEN] = mem[idx];
      assign deq_valid[i]                     = (count > CW'(i));
   end

   a_deq_num_legal : assert property (@(posedge clk) disable iff (!rst_n)
      !flush |-> (deq_req <= count))
      else $warning("ibuf: deq_num %0d exceeds count %0d, clamped", deq_num, count);

endmodule
`default_nettype wire

// File: tb/tb_ifu_ibuf_mp.sv
`default_nettype none
// ============================================================================
// tb_ifu_ibuf_mp : scoreboard bench for ifu_ibuf_mp (directed + random traffic)
// Revision: 1.0
// ============================================================================
module tb_ifu_ibuf_mp;

   localparam int DL    = 32;
   localparam int EQ    = 2;
   localparam int DQ    = 2;
   localparam int DEPTH = 16;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          flush    = 1'b0;
   logic [1:0]    enq_num  = '0;
   logic [1:0]    deq_num  = '0;
   logic [EQ*DL-1:0] enq_data = '0;
   logic          enq_ready;
   logic          empty;
   logic          full;
   logic [DQ-1:0] deq_valid;
   logic [DQ*DL-1:0] deq_data;
   logic [4:0]    count;

   int            tests   = 0;
   int            fails   = 0;
   int            pre_cnt = 0;
   logic [DL-1:0] exp_q[$];

   always #5 clk = ~clk;

   ifu_ibuf_mp dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .enq_num   (enq_num),
      .enq_data  (enq_data),
      .enq_ready (enq_ready),
      .deq_valid (deq_valid),
      .deq_data  (deq_data),
      .deq_num   (deq_num),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: retire what the last edge consumed, then compare every output.
   always @(negedge clk) begin : mon
      int n;
      if (!rst_n) begin
         check("rst_count", count, 0);
         check("rst_empty", empty, 1);
         check("rst_full", full, 0);
         check("rst_valid", deq_valid, 0);
         check("rst_ready", enq_ready, 1);
      end else begin
         if (flush) begin
            exp_q.delete();
         end else begin
            n = (int'(deq_num) > pre_cnt) ? pre_cnt : int'(deq_num);
            repeat (n) void'(exp_q.pop_front());
         end
         check("count", count, exp_q.size());
         check("empty", empty, exp_q.size() == 0);
         check("full", full, exp_q.size() == DEPTH);
         check("enq_ready", enq_ready, (DEPTH - exp_q.size()) >= EQ);
         for (int i = 0; i < DQ; i++) begin
            check("deq_valid", deq_valid[i], exp_q.size() > i);
            if (exp_q.size() > i) check("deq_data", deq_data[i*DL +: DL], exp_q[i]);
         end
      end
   end

   // One cycle of stimulus; accepted words go straight into the scoreboard.
   task automatic drive(input int en, input logic [DL-1:0] a, input logic [DL-1:0] b,
                        input int dn, input bit fl);
      int pre;
      pre      = exp_q.size();
      enq_num  = 2'(en);
      enq_data = {b, a};
      deq_num  = 2'(dn);
      flush    = fl;
      pre_cnt  = pre;
      if (!fl && en != 0 && (DEPTH - pre) >= EQ) begin
         exp_q.push_back(a);
         if (en > 1) exp_q.push_back(b);
      end
      @(negedge clk);
      #1;
      enq_num = '0;
      deq_num = '0;
      flush   = 1'b0;
      pre_cnt = exp_q.size();
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      exp_q.delete();
      pre_cnt = 0;
      @(negedge clk);
      #1;
      check("async_rst_wptr", dut.wptr, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      int dmax;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;

      // Two words in, visible on both lanes one edge later.
      drive(2, 32'hAAAA_0001, 32'hBBBB_0002, 0, 0);
      check("t1_count", count, 2);
      check("t1_valid", deq_valid, 2'b11);
      check("t1_lane0", deq_data[0 +: DL], 32'hAAAA_0001);
      check("t1_lane1", deq_data[DL +: DL], 32'hBBBB_0002);
      drive(0, '0, '0, 2, 0);
      check("t1_drained", empty, 1);

      // Fill to DEPTH, reject an extra offer, then back off to 15.
      for (int k = 0; k < 8; k++) drive(2, $urandom, $urandom, 0, 0);
      check("t2_full", full, 1);
      check("t2_ready16", enq_ready, 0);
      drive(2, 32'hDEAD_0001, 32'hDEAD_0002, 0, 0);
      check("t2_drop_count", count, 16);
      drive(0, '0, '0, 1, 0);
      check("t2_count15", count, 15);
      check("t2_ready15", enq_ready, 0);
      check("t2_notfull", full, 0);

      do_reset();
      check("post_rst_count", count, 0);

      // Walk pointers to wptr=15, rptr=14, then straddle the wrap.
      drive(2, $urandom, $urandom, 0, 0);
      for (int k = 0; k < 6; k++) drive(2, $urandom, $urandom, 2, 0);
      drive(1, $urandom, $urandom, 2, 0);
      check("t3_wptr", dut.wptr, 15);
      check("t3_rptr", dut.rptr, 14);
      drive(2, 32'hCCCC_0003, 32'hDDDD_0004, 1, 0);
      check("t3_count", count, 2);
      check("t3_lane0", deq_data[0 +: DL], 32'hCCCC_0003);
      check("t3_lane1", deq_data[DL +: DL], 32'hDDDD_0004);
      drive(0, '0, '0, 2, 0);
      check("t3_rptr_wrap", dut.rptr, 17);

      // Flush wins over simultaneous enqueue and dequeue.
      drive(2, $urandom, $urandom, 0, 0);
      drive(2, $urandom, $urandom, 0, 0);
      drive(1, $urandom, $urandom, 0, 0);
      check("t4_count5", count, 5);
      drive(2, 32'hEEEE_0005, 32'hFFFF_0006, 2, 1);
      check("t4_count", count, 0);
      check("t4_empty", empty, 1);
      check("t4_ready", enq_ready, 1);
      check("t4_ptr_eq", dut.wptr, dut.rptr);
      drive(2, 32'h1111_0007, 32'h2222_0008, 0, 0);
      check("t4_lane0", deq_data[0 +: DL], 32'h1111_0007);

      // Over-consume by one: clamped to what is present.
      drive(0, '0, '0, 1, 0);
      check("t5_count1", count, 1);
      drive(0, '0, '0, 2, 0);
      check("t5_empty", empty, 1);
      check("t5_ptr_eq", dut.rptr, dut.wptr);

      for (int k = 0; k < 10000; k++) begin
         dmax = (exp_q.size() < DQ) ? exp_q.size() : DQ;
         drive($urandom_range(0, 2), $urandom, $urandom, $urandom_range(0, dmax),
               ($urandom_range(0, 31) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
